ifetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It owns the fetch PC, drives the word address of the instruction ROM (combinational read, no output register) and captures the returned word. Captured instructions are buffered in a 2-entry skid FIFO and handed to decode over a valid/ready handshake. Redirect requests from execute (taken branch, jump) flush the FIFO, and illegal fetch addresses are reported as tagged fault entries.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_skid_fifo.sv | 57 +++++
 rtl/ifetch_unit.sv | 78 +++++++
 tb/tb_ifetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: the NOP encoding and the {pc, instr, fault} entry
// that travels from fetch to decode.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between fetch and decode. The head entry is held in a
// register so decode sees stable outputs that do not depend on the push side.
module fetch_skid_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && (r_count != 2'd2 || w_pop);

  // An empty FIFO parks the head on a clean NOP entry rather than stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= EMPTY_ENTRY;
      r_tail  <= EMPTY_ENTRY;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_head  <= EMPTY_ENTRY;
      r_count <= 2'd0;
    end else if (w_push && !w_pop) begin
      if (r_count == 2'd0) begin
        r_head <= i_entry;
      end else begin
        r_tail <= i_entry;
      end
      r_count <= r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      r_head  <= (r_count == 2'd2) ? r_tail : EMPTY_ENTRY;
      r_count <= r_count - 2'd1;
    end else if (w_push && w_pop) begin
      if (r_count == 2'd1) begin
        r_head <= i_entry;
      end else begin
        r_head <= r_tail;
        r_tail <= i_entry;
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads the combinational ROM,
// flags misaligned/out-of-range PCs as fault entries and feeds the skid FIFO.
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [31:0]           if_pc,
  output logic                  if_fault
);

  logic [31:0]  r_fpc;
  logic         r_halted;
  logic [1:0]   w_count;
  logic         w_pop;
  logic         w_fire;
  logic         w_fault;
  fetch_entry_t w_pushEntry;
  fetch_entry_t w_head;

  assign rom_addr = r_fpc[ADDR_WIDTH+1:2];

  assign w_pop   = if_valid && if_ready;
  assign w_fire  = !r_halted && !redirect_valid && (w_count != 2'd2 || w_pop);
  assign w_fault = (r_fpc[1:0] != 2'b00) || (|r_fpc[31:ADDR_WIDTH+2]);

  always_comb begin
    w_pushEntry = '{pc: r_fpc, instr: rom_data, fault: 1'b0};
    if (w_fault) begin
      w_pushEntry = '{pc: r_fpc, instr: NOP_INSTR, fault: 1'b1};
    end
  end

  // A faulting fetch pins the PC and halts; only a redirect restarts fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc    <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_fpc    <= redirect_pc;
      r_halted <= 1'b0;
    end else if (w_fire) begin
      if (w_fault) begin
        r_halted <= 1'b1;
      end else begin
        r_fpc <= r_fpc + 32'd4;
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fire),
    .i_entry (w_pushEntry),
    .i_pop   (w_pop && !redirect_valid),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign if_valid = (w_count != 2'd0);
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;
  assign if_fault = w_head.fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: ROM word i holds 0x1000_0000+i, and each
// step compares the decode-side outputs against hand-computed values.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  int errors;
  int checks;

  ifetch_unit #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = 32'h1000_0000 + {24'h0, rom_addr};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] redirPc, input logic ready);
    redirect_valid = redir;
    redirect_pc    = redirPc;
    if_ready       = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEntry(input string tag, input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    checkOutput({tag, "_valid"}, {31'h0, if_valid}, 32'd1);
    checkOutput({tag, "_pc"}, if_pc, pc);
    checkOutput({tag, "_instr"}, if_instr, instr);
    checkOutput({tag, "_fault"}, {31'h0, if_fault}, {31'h0, fault});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();

    checkOutput("rst_valid", {31'h0, if_valid}, 32'd0);
    checkOutput("rst_instr", if_instr, 32'h0000_0013);
    checkOutput("rst_pc", if_pc, 32'h0);
    checkOutput("rst_fault", {31'h0, if_fault}, 32'd0);
    checkOutput("rst_romaddr", {24'h0, rom_addr}, 32'h0);

    // Streaming with if_ready high: one instruction per cycle.
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkEntry($sformatf("stream%0d", i), 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0);
    end

    // Back-pressure: FIFO saturates at two entries and the PC freezes.
    applyStimulus(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("bp_valid", {31'h0, if_valid}, 32'd1);
    checkOutput("bp_pc", if_pc, 32'h0);
    checkOutput("bp_romaddr", {24'h0, rom_addr}, 32'd2);

    // Reset mid-stream with a full FIFO takes effect immediately.
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", {31'h0, if_valid}, 32'd0);
    checkOutput("midrst_romaddr", {24'h0, rom_addr}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkEntry("release0", 32'h0, 32'h1000_0000, 1'b0);
    for (int j = 1; j < 4; j++) begin
      tick();
      checkEntry($sformatf("release%0d", j), 32'(4 * j), 32'h1000_0000 + 32'(j), 1'b0);
    end

    // Redirect while full: one bubble, then the target with no stale entries.
    applyStimulus(1'b1, 32'h40, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir_bubble", {31'h0, if_valid}, 32'd0);
    checkOutput("redir_romaddr", {24'h0, rom_addr}, 32'h10);
    tick();
    checkEntry("redir_t0", 32'h40, 32'h1000_0010, 1'b0);
    tick();
    checkEntry("redir_t1", 32'h44, 32'h1000_0011, 1'b0);
    tick();
    checkEntry("redir_t2", 32'h48, 32'h1000_0012, 1'b0);

    // Misaligned target: a single fault entry, then halted.
    applyStimulus(1'b1, 32'h42, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkEntry("misalign", 32'h42, 32'h0000_0013, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("halt%0d_valid", i), {31'h0, if_valid}, 32'd0);
    end
    checkOutput("halt_romaddr", {24'h0, rom_addr}, 32'h10);

    applyStimulus(1'b1, 32'h8, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("resume_bubble", {31'h0, if_valid}, 32'd0);
    tick();
    checkEntry("resume", 32'h8, 32'h1000_0002, 1'b0);

    // Walk off the end of the ROM: 0x3FC is the last legal word.
    applyStimulus(1'b1, 32'h3F8, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkEntry("top0", 32'h3F8, 32'h1000_00FE, 1'b0);
    tick();
    checkEntry("top1", 32'h3FC, 32'h1000_00FF, 1'b0);
    tick();
    checkEntry("oor", 32'h400, 32'h0000_0013, 1'b1);
    tick();
    checkOutput("oor_halt0", {31'h0, if_valid}, 32'd0);
    tick();
    checkOutput("oor_halt1", {31'h0, if_valid}, 32'd0);

    // Reset while halted restarts fetch from the reset PC.
    rst = 1'b1;
    #1;
    checkOutput("haltrst_valid", {31'h0, if_valid}, 32'd0);
    checkOutput("haltrst_romaddr", {24'h0, rom_addr}, 32'd0);
    rst = 1'b0;
    tick();
    checkEntry("restart", 32'h0, 32'h1000_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
